// File: rtl/exe_muldiv_stage_pkg.sv
// Shared constants and types for the execute stage and its iterative mul/div engine.
// Holds command codes, datapath widths, FSM state codes and the EXE/MEM bundle types.
package exe_muldiv_stage_pkg;

    localparam int WORD_LEN          = 16;
    localparam int EXE_CMD_LEN       = 4;
    localparam int REG_FILE_ADDR_LEN = 3;
    localparam int CNT_LEN           = $clog2(WORD_LEN);

    localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = 4'd0;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SUB = 4'd1;
    localparam logic [EXE_CMD_LEN-1:0] EXE_AND = 4'd2;
    localparam logic [EXE_CMD_LEN-1:0] EXE_OR  = 4'd3;
    localparam logic [EXE_CMD_LEN-1:0] EXE_XOR = 4'd4;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SLL = 4'd5;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SRL = 4'd6;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SRA = 4'd7;
    localparam logic [EXE_CMD_LEN-1:0] EXE_MUL = 4'd8;
    localparam logic [EXE_CMD_LEN-1:0] EXE_DIV = 4'd9;
    localparam logic [EXE_CMD_LEN-1:0] EXE_REM = 4'd10;
    localparam logic [EXE_CMD_LEN-1:0] EXE_NOP = 4'd15;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef enum logic [1:0] {
        MD_MUL = 2'd0,
        MD_DIV = 2'd1,
        MD_REM = 2'd2
    } md_op_e;

    typedef struct packed {
        logic [WORD_LEN-1:0]          st_value;
        logic [REG_FILE_ADDR_LEN-1:0] dest;
        logic                         wb_en;
        logic                         mem_r_en;
        logic                         mem_w_en;
    } ctrl_t;

    typedef struct packed {
        logic [WORD_LEN-1:0] result;
        ctrl_t               ctrl;
        logic                illegal;
    } exe_mem_t;

endpackage

// File: rtl/exe_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and, with EXE_DIV_EN, restoring divide/remainder.
// Ports: start_i loads operands, step_i advances one bit, last_o flags the final step,
// result_o is the value the final step produces (valid while last_o is high).
module exe_iter_muldiv
    import exe_muldiv_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                step_i,
    input  md_op_e              op_i,
    input  logic [WORD_LEN-1:0] a_i,
    input  logic [WORD_LEN-1:0] b_i,
    output logic                last_o,
    output logic [WORD_LEN-1:0] result_o
);

    md_op_e              op_q, op_d;
    logic [WORD_LEN-1:0] a_q, a_d;
    logic [WORD_LEN-1:0] b_q, b_d;
    logic [WORD_LEN-1:0] acc_q, acc_d;
    logic [CNT_LEN-1:0]  cnt_q, cnt_d;

    // a_q: multiplicand (MUL) or divisor (DIV/REM)
    // b_q: multiplier (MUL) or dividend shifting into quotient
    // acc_q: product (MUL) or partial remainder
    logic [WORD_LEN-1:0] mul_acc;
    logic [WORD_LEN-1:0] nxt_a, nxt_b, nxt_acc;

`ifdef EXE_DIV_EN
    logic [WORD_LEN:0]   div_rs, div_diff;
    logic                div_ge;
    logic [WORD_LEN-1:0] div_r, div_q;
`endif

    assign mul_acc = acc_q + (b_q[0] ? a_q : '0);

`ifdef EXE_DIV_EN
    // Remainder is always below the divisor, so WORD_LEN+1 bits
    // hold the shifted remainder; the top bit of the difference
    // is the borrow.
    assign div_rs   = {acc_q, b_q[WORD_LEN-1]};
    assign div_diff = div_rs - {1'b0, a_q};
    assign div_ge   = ~div_diff[WORD_LEN];
    assign div_r    = div_ge ? div_diff[WORD_LEN-1:0]
                             : div_rs[WORD_LEN-1:0];
    assign div_q    = {b_q[WORD_LEN-2:0], div_ge};

    always_comb begin
        if (op_q == MD_MUL) begin
            nxt_acc = mul_acc;
            nxt_a   = a_q << 1;
            nxt_b   = b_q >> 1;
        end else begin
            nxt_acc = div_r;
            nxt_a   = a_q;
            nxt_b   = div_q;
        end
    end

    always_comb begin
        case (op_q)
            MD_DIV:  result_o = div_q;
            MD_REM:  result_o = div_r;
            default: result_o = mul_acc;
        endcase
    end
`else
    assign nxt_acc  = mul_acc;
    assign nxt_a    = a_q << 1;
    assign nxt_b    = b_q >> 1;
    assign result_o = (op_q == MD_MUL) ? mul_acc : '0;
`endif

    assign last_o = (cnt_q == '0);

    always_comb begin
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (start_i) begin
            op_d  = op_i;
            acc_d = '0;
            cnt_d = CNT_LEN'(WORD_LEN - 1);
            if (op_i == MD_MUL) begin
                a_d = a_i;
                b_d = b_i;
            end else begin
                a_d = b_i;
                b_d = a_i;
            end
        end else if (step_i) begin
            a_d   = nxt_a;
            b_d   = nxt_b;
            acc_d = nxt_acc;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= MD_MUL;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/exe_muldiv_stage.sv
// Execute stage: single-cycle ALU plus iterative MUL (and DIV/REM when EXE_DIV_EN is defined).
// Inputs come from ID/EXE (exe_cmd, val1/2, st_value_in, dest_in, ctrl, flush); outputs are the
// registered EXE/MEM bundle, a registered illegal_cmd pulse and a combinational stall.
module exe_muldiv_stage
    import exe_muldiv_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [EXE_CMD_LEN-1:0]       exe_cmd,
    input  logic [WORD_LEN-1:0]          val1,
    input  logic [WORD_LEN-1:0]          val2,
    input  logic [WORD_LEN-1:0]          st_value_in,
    input  logic [REG_FILE_ADDR_LEN-1:0] dest_in,
    input  logic                         wb_en_in,
    input  logic                         mem_r_en_in,
    input  logic                         mem_w_en_in,
    input  logic                         flush,
    output logic                         stall,
    output logic [WORD_LEN-1:0]          result,
    output logic [WORD_LEN-1:0]          st_value,
    output logic [REG_FILE_ADDR_LEN-1:0] dest,
    output logic                         wb_en,
    output logic                         mem_r_en,
    output logic                         mem_w_en,
    output logic                         illegal_cmd
);

    logic [0:0]          state_q, state_d;
    exe_mem_t            out_q, out_d;
    ctrl_t               lat_q, lat_d;
    ctrl_t               in_ctrl;
    logic                is_mul, dr_ok, dz, legal;
    logic                md_go, eng_last;
    logic [WORD_LEN-1:0] alu_res, eng_res;
    logic [CNT_LEN-1:0]  sh;
    md_op_e              md_op;

    assign in_ctrl.st_value = st_value_in;
    assign in_ctrl.dest     = dest_in;
    assign in_ctrl.wb_en    = wb_en_in;
    assign in_ctrl.mem_r_en = mem_r_en_in;
    assign in_ctrl.mem_w_en = mem_w_en_in;

    assign is_mul = (exe_cmd == EXE_MUL);

`ifdef EXE_DIV_EN
    assign dr_ok = (exe_cmd == EXE_DIV) || (exe_cmd == EXE_REM);
    // Divide by zero has a fixed answer, so it skips the engine.
    assign dz    = dr_ok && (val2 == '0);
`else
    assign dr_ok = 1'b0;
    assign dz    = 1'b0;
`endif

    assign legal = (exe_cmd <= EXE_MUL) || (exe_cmd == EXE_NOP) || dr_ok;
    assign md_go = (state_q == ST_IDLE) && !flush && (is_mul || (dr_ok && !dz));
    assign stall = md_go || ((state_q == ST_BUSY) && !eng_last);

    assign md_op = is_mul ? MD_MUL :
                   (exe_cmd == EXE_DIV) ? MD_DIV : MD_REM;

    assign sh = val2[CNT_LEN-1:0];

    always_comb begin
        case (exe_cmd)
            EXE_ADD: alu_res = val1 + val2;
            EXE_SUB: alu_res = val1 - val2;
            EXE_AND: alu_res = val1 & val2;
            EXE_OR:  alu_res = val1 | val2;
            EXE_XOR: alu_res = val1 ^ val2;
            EXE_SLL: alu_res = val1 << sh;
            EXE_SRL: alu_res = val1 >> sh;
            EXE_SRA: alu_res = $unsigned($signed(val1) >>> sh);
`ifdef EXE_DIV_EN
            EXE_DIV: alu_res = '1;
            EXE_REM: alu_res = val1;
`endif
            default: alu_res = '0;
        endcase
    end

    exe_iter_muldiv u_engine (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_go),
        .step_i   (state_q == ST_BUSY),
        .op_i     (md_op),
        .a_i      (val1),
        .b_i      (val2),
        .last_o   (eng_last),
        .result_o (eng_res)
    );

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        out_d   = '0;
        if (state_q == ST_BUSY) begin
            // flush is ignored here: the op is already committed.
            if (eng_last) begin
                out_d.result = eng_res;
                out_d.ctrl   = lat_q;
                state_d      = ST_IDLE;
            end
        end else if (!flush) begin
            if (!legal) begin
                out_d.illegal = 1'b1;
            end else if (md_go) begin
                lat_d   = in_ctrl;
                state_d = ST_BUSY;
            end else if (exe_cmd != EXE_NOP) begin
                out_d.result = alu_res;
                out_d.ctrl   = in_ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            out_q   <= out_d;
        end
    end

    assign result      = out_q.result;
    assign st_value    = out_q.ctrl.st_value;
    assign dest        = out_q.ctrl.dest;
    assign wb_en       = out_q.ctrl.wb_en;
    assign mem_r_en    = out_q.ctrl.mem_r_en;
    assign mem_w_en    = out_q.ctrl.mem_w_en;
    assign illegal_cmd = out_q.illegal;

endmodule

// File: tb/tb_exe_muldiv_stage.sv
// Self-checking bench for exe_muldiv_stage: directed cases with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_exe_muldiv_stage;

    localparam int W = 16;
`ifdef EXE_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  exe_cmd;
    logic [15:0] val1, val2, st_value_in;
    logic [2:0]  dest_in;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, flush;
    logic        stall;
    logic [15:0] result, st_value;
    logic [2:0]  dest;
    logic        wb_en, mem_r_en, mem_w_en, illegal_cmd;

    always #5 clk = ~clk;

    exe_muldiv_stage dut (
        .clk         (clk),
        .rst         (rst),
        .exe_cmd     (exe_cmd),
        .val1        (val1),
        .val2        (val2),
        .st_value_in (st_value_in),
        .dest_in     (dest_in),
        .wb_en_in    (wb_en_in),
        .mem_r_en_in (mem_r_en_in),
        .mem_w_en_in (mem_w_en_in),
        .flush       (flush),
        .stall       (stall),
        .result      (result),
        .st_value    (st_value),
        .dest        (dest),
        .wb_en       (wb_en),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .illegal_cmd (illegal_cmd)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // model state: cycles left before a long op's result appears
    int          mdleft = 0;
    logic [15:0] pend_res, pend_st;
    logic [2:0]  pend_dst;
    logic        pend_wb, pend_mr, pend_mw;

    // expectations for the current cycle / next output
    logic [15:0] e_res, e_st;
    logic [2:0]  e_dst;
    logic        e_wb, e_mr, e_mw, e_ill;
    bit          e_real, e_stall, e_stall_chk;
    logic        dut_stall_s;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h @%0t",
                      nm, act, exp, $time);
    endtask

    function automatic logic [15:0] ref_op(input logic [3:0] c,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
        logic signed [15:0] s;
        int unsigned sh;
        logic [15:0] r;
        sh = b % 16;
        s  = a;
        case (c)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << sh;
            4'd6:  r = a >> sh;
            4'd7:  r = s >>> sh;
            4'd8:  r = a * b;
            4'd9:  r = (b == 0) ? 16'hFFFF : a / b;
            4'd10: r = (b == 0) ? a : a % b;
            default: r = 16'h0;
        endcase
        return r;
    endfunction

    task automatic model_cycle();
        bit md, legal, dr;
        e_stall_chk = 1; e_stall = 0; e_real = 0;
        e_res = 0; e_st = 0; e_dst = 0;
        e_wb = 0; e_mr = 0; e_mw = 0; e_ill = 0;
        if (rst) begin
            mdleft = 0;
            e_stall_chk = 0;
            e_real = 1;
        end else if (mdleft > 0) begin
            mdleft--;
            if (mdleft == 0) begin
                e_real = 1;
                e_res = pend_res; e_st = pend_st; e_dst = pend_dst;
                e_wb = pend_wb; e_mr = pend_mr; e_mw = pend_mw;
            end else begin
                e_stall = 1;
            end
        end else if (!flush) begin
            dr    = DIV_EN && (exe_cmd == 9 || exe_cmd == 10);
            legal = (exe_cmd <= 8) || (exe_cmd == 15) || dr;
            md    = (exe_cmd == 8) || (dr && val2 != 0);
            if (!legal) begin
                e_ill = 1;
            end else if (md) begin
                mdleft = W;
                e_stall = 1;
                pend_res = ref_op(exe_cmd, val1, val2);
                pend_st = st_value_in; pend_dst = dest_in;
                pend_wb = wb_en_in; pend_mr = mem_r_en_in;
                pend_mw = mem_w_en_in;
            end else if (exe_cmd != 15) begin
                e_real = 1;
                e_res = ref_op(exe_cmd, val1, val2);
                e_st = st_value_in; e_dst = dest_in;
                e_wb = wb_en_in; e_mr = mem_r_en_in; e_mw = mem_w_en_in;
            end
        end
    endtask

    // called at a negedge with this cycle's inputs applied
    task automatic step();
        model_cycle();
        #1;
        dut_stall_s = stall;
        if (e_stall_chk) chk("stall", stall, e_stall);
        @(negedge clk);
        chk("wb_en", wb_en, e_wb);
        chk("mem_r_en", mem_r_en, e_mr);
        chk("mem_w_en", mem_w_en, e_mw);
        chk("illegal_cmd", illegal_cmd, e_ill);
        if (e_real) begin
            chk("result", result, e_res);
            chk("dest", dest, e_dst);
            chk("st_value", st_value, e_st);
        end
    endtask

    task automatic set_in(input logic [3:0] c, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] d,
                          input logic w);
        exe_cmd = c; val1 = a; val2 = b; dest_in = d; wb_en_in = w;
        mem_r_en_in = 0; mem_w_en_in = 0; flush = 0;
        st_value_in = 16'($urandom);
    endtask

    task automatic run_op(input string nm, input logic [3:0] c,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] d, input logic [15:0] lit,
                          input int lit_lat, input int lit_st);
        int n, st;
        bit done;
        set_in(c, a, b, d, 1'b1);
        n = 0; st = 0; done = 0;
        while (!done && n < 40) begin
            step();
            n++;
            st += int'(dut_stall_s);
            done = e_real;
        end
        chk({nm, "_res"}, result, lit);
        chk({nm, "_lat"}, n, lit_lat);
        chk({nm, "_stalls"}, st, lit_st);
    endtask

    task automatic ill_op(input string nm, input logic [3:0] c);
        set_in(c, 16'd5, 16'd3, 3'd2, 1'b1);
        step();
        chk({nm, "_ill"}, illegal_cmd, 1);
        chk({nm, "_wb"}, wb_en, 0);
        chk({nm, "_stall"}, dut_stall_s, 0);
        set_in(4'd15, 0, 0, 0, 1'b0);
        step();
        chk({nm, "_ill_pulse"}, illegal_cmd, 0);
    endtask

    initial begin
        rst = 1;
        set_in(4'd15, 0, 0, 0, 1'b0);
        @(negedge clk);
        step();
        step();
        chk("reset_result", result, 0);
        chk("reset_wb", wb_en, 0);
        chk("reset_stall", stall, 0);
        rst = 0;

        run_op("add", 4'd0, 16'h0003, 16'h0004, 3'd5, 16'h0007, 1, 0);
        chk("add_dest", dest, 5);
        chk("add_wb", wb_en, 1);
        run_op("mul", 4'd8, 16'h0012, 16'h0034, 3'd1, 16'h03A8, 17, 16);
`ifdef EXE_DIV_EN
        run_op("div", 4'd9, 16'd100, 16'd7, 3'd2, 16'd14, 17, 16);
        run_op("rem", 4'd10, 16'd100, 16'd7, 3'd3, 16'd2, 17, 16);
        run_op("div0", 4'd9, 16'd5, 16'd0, 3'd4, 16'hFFFF, 1, 0);
        run_op("rem0", 4'd10, 16'd5, 16'd0, 3'd4, 16'd5, 1, 0);
`else
        ill_op("div_off", 4'd9);
        ill_op("rem_off", 4'd10);
`endif
        run_op("b2b_mul", 4'd8, 16'd7, 16'd9, 3'd6, 16'd63, 17, 16);
        run_op("b2b_add", 4'd0, 16'hFFFF, 16'h0002, 3'd7, 16'h0001, 1, 0);
        set_in(4'd15, 0, 0, 0, 1'b0);
        step();
        chk("b2b_nodup", wb_en, 0);

        set_in(4'd8, 16'h1234, 16'h5678, 3'd1, 1'b1);
        repeat (5) step();
        rst = 1;
        step();
        rst = 0;
        chk("rst_mid_result", result, 0);
        chk("rst_mid_wb", wb_en, 0);
        run_op("post_rst_add", 4'd0, 16'd10, 16'd20, 3'd3, 16'd30, 1, 0);

        ill_op("code12", 4'd12);
        set_in(4'd1, 16'd9, 16'd4, 3'd2, 1'b1);
        flush = 1;
        step();
        chk("flush_wb", wb_en, 0);
        flush = 0;

        for (int i = 0; i < 600; i++) begin
            exe_cmd = 4'($urandom_range(0, 15));
            val1 = 16'($urandom);
            val2 = ($urandom % 8 == 0) ? 16'h0 : 16'($urandom);
            st_value_in = 16'($urandom);
            dest_in = 3'($urandom);
            wb_en_in = 1'($urandom);
            mem_r_en_in = 1'($urandom);
            mem_w_en_in = 1'($urandom);
            flush = ($urandom % 8 == 0);
            rst = ($urandom % 150 == 0);
            step();
            rst = 0;
            while (e_stall) begin
                flush = ($urandom % 4 == 0);
                rst = ($urandom % 60 == 0);
                step();
                rst = 0;
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
